compressed_stream_unpacker: RTL and testbench

COMPRESSED_STREAM_UNPACKER -- requirements
Module: compressed_stream_unpacker

---
 rtl/compressed_stream_unpacker.sv | 167 ++++++++++++++++
 tb/tb_compressed_stream_unpacker.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compressed_stream_unpacker.sv
// rtl/compressed_stream_unpacker.sv - splits a packed word stream into tokens and escaped raw words
module compressed_stream_unpacker #(
  parameter int                 TOKEN_W      = 4,
  parameter logic [TOKEN_W-1:0] ESCAPE       = 4'b1111,
  parameter int                 ADDR_W       = 32,
  parameter int                 STREAM_WORDS = 77
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_is_raw,
  output logic [31:0]       out_data,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LP_WORDS = ADDR_W'(STREAM_WORDS);
  localparam logic [ADDR_W-1:0] LP_ONE   = ADDR_W'(1);
  localparam logic [6:0]        LP_TOK   = 7'(TOKEN_W);
  localparam logic [6:0]        LP_RAW   = 7'(TOKEN_W + 32);
  localparam logic [6:0]        LP_HALF  = 7'd32;

  typedef enum logic [1:0] {IDLE, RUN, DISCARD} state_t;

  state_t            r_state, w_state_nxt;
  logic [63:0]       r_buf, w_buf_nxt;
  logic [6:0]        r_count, w_count_nxt;
  logic              r_outstanding, w_outstanding_nxt;
  logic [ADDR_W-1:0] r_next_addr, w_next_addr_nxt;
  logic              r_mem_req, w_mem_req_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic              r_out_is_raw, w_out_is_raw_nxt;
  logic [31:0]       r_out_data, w_out_data_nxt;
  logic              r_done, w_done_nxt;

  // The arriving word is merged before decode so a token can leave in the same cycle it lands.
  logic               w_accept;
  logic               w_pending;
  logic [63:0]        w_buf_a;
  logic [6:0]         w_cnt_a;
  logic [TOKEN_W-1:0] w_top;
  logic               w_can_load;

  assign w_accept   = (r_state == RUN) && r_outstanding && mem_rvalid;
  assign w_pending  = r_outstanding && !mem_rvalid;
  assign w_buf_a    = w_accept ? (r_buf | ({mem_rdata, 32'b0} >> r_count)) : r_buf;
  assign w_cnt_a    = w_accept ? (r_count + LP_HALF) : r_count;
  assign w_top      = w_buf_a[63 -: TOKEN_W];
  assign w_can_load = !r_out_valid || out_ready;

  always_comb begin
    w_state_nxt       = r_state;
    w_buf_nxt         = r_buf;
    w_count_nxt       = r_count;
    w_outstanding_nxt = r_outstanding;
    w_next_addr_nxt   = r_next_addr;
    w_mem_req_nxt     = 1'b0;
    w_mem_addr_nxt    = r_mem_addr;
    w_out_valid_nxt   = r_out_valid;
    w_out_is_raw_nxt  = r_out_is_raw;
    w_out_data_nxt    = r_out_data;
    w_done_nxt        = 1'b0;

    if (redirect_valid) begin
      w_buf_nxt       = '0;
      w_count_nxt     = '0;
      w_out_valid_nxt = 1'b0;
      w_next_addr_nxt = redirect_addr;
      if (w_pending) begin
        w_state_nxt = DISCARD;
      end else begin
        w_state_nxt       = RUN;
        w_outstanding_nxt = 1'b0;
        if (redirect_addr < LP_WORDS) begin
          w_mem_req_nxt     = 1'b1;
          w_mem_addr_nxt    = redirect_addr;
          w_next_addr_nxt   = redirect_addr + LP_ONE;
          w_outstanding_nxt = 1'b1;
        end
      end
    end else begin
      case (r_state)
        DISCARD: begin
          if (mem_rvalid) begin
            w_outstanding_nxt = 1'b0;
            w_state_nxt       = RUN;
          end
        end
        RUN: begin
          w_buf_nxt   = w_buf_a;
          w_count_nxt = w_cnt_a;
          if (w_accept) w_outstanding_nxt = 1'b0;
          if (w_can_load) begin
            w_out_valid_nxt = 1'b0;
            if (w_cnt_a >= LP_TOK && w_top != ESCAPE) begin
              w_out_valid_nxt  = 1'b1;
              w_out_is_raw_nxt = 1'b0;
              w_out_data_nxt   = 32'(w_top);
              w_buf_nxt        = w_buf_a << TOKEN_W;
              w_count_nxt      = w_cnt_a - LP_TOK;
            end else if (w_cnt_a >= LP_RAW && w_top == ESCAPE) begin
              w_out_valid_nxt  = 1'b1;
              w_out_is_raw_nxt = 1'b1;
              w_out_data_nxt   = w_buf_a[63-TOKEN_W -: 32];
              w_buf_nxt        = w_buf_a << (TOKEN_W + 32);
              w_count_nxt      = w_cnt_a - LP_RAW;
            end
          end
          if (!r_outstanding && r_count <= LP_HALF && r_next_addr < LP_WORDS) begin
            w_mem_req_nxt     = 1'b1;
            w_mem_addr_nxt    = r_next_addr;
            w_next_addr_nxt   = r_next_addr + LP_ONE;
            w_outstanding_nxt = 1'b1;
          end
          // Leftover bits below a token, or an escape whose payload never arrives, are pad.
          w_done_nxt = (w_next_addr_nxt >= LP_WORDS) && !w_outstanding_nxt && !w_out_valid_nxt &&
                       ((w_count_nxt < LP_TOK) ||
                        (w_buf_nxt[63 -: TOKEN_W] == ESCAPE && w_count_nxt < LP_RAW));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_buf         <= '0;
      r_count       <= '0;
      r_outstanding <= 1'b0;
      r_next_addr   <= '0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_out_valid   <= 1'b0;
      r_out_is_raw  <= 1'b0;
      r_out_data    <= '0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_buf         <= w_buf_nxt;
      r_count       <= w_count_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_next_addr   <= w_next_addr_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_out_is_raw  <= w_out_is_raw_nxt;
      r_out_data    <= w_out_data_nxt;
      r_done        <= w_done_nxt;
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign out_valid  = r_out_valid;
  assign out_is_raw = r_out_is_raw;
  assign out_data   = r_out_data;
  assign done       = r_done;

endmodule

// File: tb/tb_compressed_stream_unpacker.sv
// tb/tb_compressed_stream_unpacker.sv - directed bench for compressed_stream_unpacker
module tb_compressed_stream_unpacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready;
  logic        out_is_raw;
  logic [31:0] out_data;
  logic        done;

  logic        redirect_valid2;
  logic [31:0] redirect_addr2;
  logic        mem_req2;
  logic [31:0] mem_addr2;
  logic        mem_rvalid2 = 1'b0;
  logic [31:0] mem_rdata2 = '0;
  logic        out_valid2;
  logic        out_ready2;
  logic        out_is_raw2;
  logic [31:0] out_data2;
  logic        done2;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem  [0:127];
  logic [31:0] mem2 [0:3];
  int          lat = 1;
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_addr = '0;

  compressed_stream_unpacker u_dut (
    .clk(clk), .reset(reset_n),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_is_raw(out_is_raw), .out_data(out_data), .done(done)
  );

  compressed_stream_unpacker #(.STREAM_WORDS(2)) u_dut2 (
    .clk(clk), .reset(reset_n),
    .redirect_valid(redirect_valid2), .redirect_addr(redirect_addr2),
    .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_rvalid(mem_rvalid2), .mem_rdata(mem_rdata2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_is_raw(out_is_raw2), .out_data(out_data2), .done(done2)
  );

  // Memory with adjustable latency; it keeps answering through a DUT reset.
  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    if (m_busy) begin
      if (m_cnt <= 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= mem[m_addr[6:0]];
        m_busy     <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
    if (mem_req) begin
      if (lat <= 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= mem[mem_addr[6:0]];
      end else begin
        m_busy <= 1'b1;
        m_cnt  <= lat - 1;
        m_addr <= mem_addr;
      end
    end
  end

  always @(posedge clk) begin
    mem_rvalid2 <= mem_req2;
    mem_rdata2  <= mem2[mem_addr2[1:0]];
  end

  task automatic do_redirect(input logic [31:0] addr);
    redirect_valid = 1'b1;
    redirect_addr  = addr;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic quiesce;
    do_redirect(32'd100);
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (done !== 1'b0 || done2 !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b/%0b exp=0/0", done, done2); end
    checks++; if (out_is_raw !== 1'b0) begin errors++; $display("FAIL reset_out_is_raw got=%0b exp=0", out_is_raw); end
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL idle_quiet cycle=%0d mem_req=%0b out_valid=%0b exp=0/0", c, mem_req, out_valid);
      end
    end
  endtask

  task automatic test_tokens;
    out_ready = 1'b1;
    do_redirect(32'd0);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd0) begin errors++; $display("FAIL tok_first_req got=%0b/%h exp=1/0", mem_req, mem_addr); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL tok_early_valid got=%0b exp=0", out_valid); end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_is_raw !== 1'b0 || out_data !== 32'(i + 1)) begin
        errors++; $display("FAIL tok_seq idx=%0d got v=%0b raw=%0b d=%h exp v=1 raw=0 d=%h", i, out_valid, out_is_raw, out_data, 32'(i + 1));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_escape;
    quiesce();
    mem[10] = 32'hF1EFF2FE;
    mem[11] = 32'h10000000;
    out_ready = 1'b1;
    do_redirect(32'd10);
    for (int c = 0; c < 20 && out_valid !== 1'b1; c++) @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL esc_timeout got=%0b exp=1", out_valid); end
    checks++;
    if (out_is_raw !== 1'b1 || out_data !== 32'h1EFF2FE1) begin
      errors++; $display("FAIL esc_raw got raw=%0b d=%h exp raw=1 d=1eff2fe1", out_is_raw, out_data);
    end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_is_raw !== 1'b0 || out_data !== 32'h0) begin
        errors++; $display("FAIL esc_zero idx=%0d got v=%0b raw=%0b d=%h exp v=1 raw=0 d=0", i, out_valid, out_is_raw, out_data);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] q[$];
    logic [63:0] exp_bits;
    logic [3:0]  nib;
    int          stall_left;
    bit          stalled;
    quiesce();
    mem[20] = 32'h12345678;
    mem[21] = 32'h9ABCDEDC;
    exp_bits = 64'h123456789ABCDEDC;
    stall_left = 0;
    stalled = 1'b0;
    out_ready = 1'b1;
    do_redirect(32'd20);
    for (int c = 0; c < 80 && q.size() < 16; c++) begin
      @(negedge clk);
      if (stall_left > 0) begin
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h4 || out_is_raw !== 1'b0) begin
          errors++; $display("FAIL bp_hold left=%0d got v=%0b d=%h exp v=1 d=4", stall_left, out_valid, out_data);
        end
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_no_req left=%0d got=%0b exp=0", stall_left, mem_req); end
        stall_left--;
      end else begin
        out_ready = 1'b1;
        if (out_valid === 1'b1) begin
          q.push_back(out_data);
          if (q.size() == 3 && !stalled) begin
            stalled = 1'b1;
            stall_left = 5;
          end
        end
      end
    end
    out_ready = 1'b1;
    checks++; if (q.size() != 16) begin errors++; $display("FAIL bp_count got=%0d exp=16", q.size()); end
    for (int i = 0; i < 16 && i < q.size(); i++) begin
      nib = exp_bits[63-4*i -: 4];
      checks++;
      if (q[i] !== 32'(nib)) begin errors++; $display("FAIL bp_seq idx=%0d got=%h exp=%h", i, q[i], 32'(nib)); end
    end
  endtask

  task automatic test_redirect_discard;
    bit          got_req, got_out;
    logic [31:0] first_addr, first_data;
    quiesce();
    mem[30] = 32'h77777777;
    mem[5]  = 32'h3C3C3C3C;
    out_ready = 1'b1;
    got_req = 1'b0;
    got_out = 1'b0;
    first_addr = '0;
    first_data = '0;
    do_redirect(32'd30);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd30) begin errors++; $display("FAIL disc_req30 got=%0b/%h exp=1/1e", mem_req, mem_addr); end
    do_redirect(32'd5);
    for (int c = 0; c < 20 && !got_out; c++) begin
      if (mem_req === 1'b1 && !got_req) begin got_req = 1'b1; first_addr = mem_addr; end
      if (out_valid === 1'b1) begin got_out = 1'b1; first_data = out_data; end
      if (!got_out) @(negedge clk);
    end
    checks++; if (!got_req || first_addr !== 32'd5) begin errors++; $display("FAIL disc_addr got=%0b/%h exp=1/5", got_req, first_addr); end
    checks++; if (!got_out || first_data !== 32'h3) begin errors++; $display("FAIL disc_first got=%0b/%h exp=1/3", got_out, first_data); end
  endtask

  task automatic test_drain;
    logic [63:0] exp_bits;
    logic [3:0]  nib;
    int          n, reqs, bad_addr, tok_at_done;
    bit          done_seen;
    exp_bits = 64'h123456789ABCDE21;
    mem2[0] = 32'h12345678;
    mem2[1] = 32'h9ABCDE21;
    n = 0; reqs = 0; bad_addr = 0; tok_at_done = -1; done_seen = 1'b0;
    out_ready2 = 1'b1;
    checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL drain_pre_done got=%0b exp=0", done2); end
    redirect_valid2 = 1'b1;
    redirect_addr2  = 32'd0;
    @(negedge clk);
    redirect_valid2 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (mem_req2 === 1'b1) begin
        reqs++;
        if (mem_addr2 >= 32'd2) bad_addr++;
      end
      if (out_valid2 === 1'b1) begin
        if (n < 16) begin
          nib = exp_bits[63-4*n -: 4];
          checks++;
          if (out_data2 !== 32'(nib) || out_is_raw2 !== 1'b0) begin
            errors++; $display("FAIL drain_seq idx=%0d got=%h raw=%0b exp=%h raw=0", n, out_data2, out_is_raw2, 32'(nib));
          end
        end
        n++;
      end
      if (done2 === 1'b1 && !done_seen) begin done_seen = 1'b1; tok_at_done = n; end
      @(negedge clk);
    end
    checks++; if (n != 16) begin errors++; $display("FAIL drain_count got=%0d exp=16", n); end
    checks++; if (reqs != 2 || bad_addr != 0) begin errors++; $display("FAIL drain_reqs got=%0d bad=%0d exp=2 bad=0", reqs, bad_addr); end
    checks++; if (done2 !== 1'b1 || tok_at_done != 16) begin errors++; $display("FAIL drain_done got=%0b at=%0d exp=1 at=16", done2, tok_at_done); end
    redirect_valid2 = 1'b1;
    @(negedge clk);
    redirect_valid2 = 1'b0;
    checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL drain_done_clear got=%0b exp=0", done2); end
  endtask

  task automatic test_async_reset;
    quiesce();
    mem[40] = 32'h12345678;
    lat = 1;
    out_ready = 1'b0;
    do_redirect(32'd40);
    for (int c = 0; c < 20 && out_valid !== 1'b1; c++) @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h1) begin errors++; $display("FAIL ar_pre got=%0b/%h exp=1/1", out_valid, out_data); end
    lat = 4;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd41) begin errors++; $display("FAIL ar_second_req got=%0b/%h exp=1/29", mem_req, mem_addr); end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL ar_out_data got=%h exp=0", out_data); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL ar_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_req !== 1'b0 || out_is_raw !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL ar_misc got req=%0b raw=%0b done=%0b exp=0/0/0", mem_req, out_is_raw, done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || mem_req !== 1'b0) begin
        errors++; $display("FAIL ar_quiet cycle=%0d v=%0b req=%0b exp=0/0", c, out_valid, mem_req);
      end
    end
    lat = 1;
    do_redirect(32'd0);
    for (int c = 0; c < 20 && out_valid !== 1'b1; c++) @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h1) begin errors++; $display("FAIL ar_restart got=%0b/%h exp=1/1", out_valid, out_data); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) mem2[i] = '0;
    mem[0] = 32'h12345678;
    redirect_valid  = 1'b0;
    redirect_addr   = '0;
    out_ready       = 1'b1;
    redirect_valid2 = 1'b0;
    redirect_addr2  = '0;
    out_ready2      = 1'b1;
    @(negedge clk);
    test_reset();
    test_tokens();
    test_escape();
    test_backpressure();
    test_redirect_discard();
    test_drain();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
